// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: per-instruction sequencer for an ARM-format instruction stream.
// It accepts one instruction at a time and decodes its class from bits[27:26].
// It then sequences the ALU, memory or branch strobes and retires the instruction
// with a one-cycle DONE pulse.
//
// Optional feature: define INSTR_SEQ_COND_CHECK_EN to evaluate the ARM condition
// field bits[31:28] against the latched flags. A failed condition retires the
// instruction without doing any work.
//
// Parameters
//   MUL_CYCLES   execute cycles for multiply instructions (1..15)
//   MEM_TIMEOUT  mem_req cycles without mem_ack before the access is abandoned (1..255)
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   instr_valid/instr_ready  instruction handshake (ready only while idle)
//   instruction, flags       instruction word and N,Z,C,V flags, latched on accept
//   instr_class              latched class: 00 DP, 01 LS, 10 BR, 11 UND
//   alu_en, branch_en        execute strobes
//   mem_req, mem_we, mem_ack memory request/direction/acknowledge
//   retired, err             completion pulse and error pulse (UND or timeout)
//   retire_cnt               wrapping count of retired instructions
module instr_seq_ctrl #(
    parameter int unsigned MUL_CYCLES  = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    input  logic [3:0]  flags,
    output logic [1:0]  instr_class,
    output logic        alu_en,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        branch_en,
    output logic        retired,
    output logic        err,
    output logic [15:0] retire_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned RCNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        MEM    = 3'd2,
        BRANCH = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          cls_d;
    logic                we_q, we_d;
    logic                fault_q, fault_d;
    logic                accept;
    logic                cond_ok;

    logic                ready_d, alu_d, mreq_d, mwe_d, br_d, ret_d, err_d;
    logic [RCNT_W-1:0]   rcnt_d;

    // Bits not otherwise decoded; folded here so they are visibly intentional.
    logic                unused_inputs;
    assign unused_inputs = ^{instruction, flags};

    // Execute length of a data-processing instruction; multiply wins over register shift.
    function automatic logic [CNT_W-1:0] exec_len(input logic [31:0] ins);
        if (ins[27:24] == 4'b0000 && ins[7:4] == 4'b1001)
            return CNT_W'(MUL_CYCLES);
        else if (!ins[25] && !ins[7] && ins[4])
            return CNT_W'(2);
        else
            return CNT_W'(1);
    endfunction

`ifdef INSTR_SEQ_COND_CHECK_EN
    // ARM condition evaluation; flags are {N,Z,C,V}, 1111 never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_pass(instruction[31:28], flags);
`else
    assign cond_ok = 1'b1;
`endif

    assign accept = instr_valid && instr_ready;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            instr_class <= 2'b00;
            instr_ready <= 1'b0;
            alu_en      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            branch_en   <= 1'b0;
            retired     <= 1'b0;
            err         <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            fault_q     <= fault_d;
            instr_class <= cls_d;
            instr_ready <= ready_d;
            alu_en      <= alu_d;
            mem_req     <= mreq_d;
            mem_we      <= mwe_d;
            branch_en   <= br_d;
            retired     <= ret_d;
            err         <= err_d;
            retire_cnt  <= rcnt_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they align with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cls_d   = instr_class;
        we_d    = we_q;
        fault_d = fault_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cls_d   = instruction[27:26];
                    we_d    = ~instruction[20];
                    fault_d = 1'b0;
                    cnt_d   = '0;
                    if (!cond_ok) begin
                        state_d = DONE;
                    end else begin
                        case (instruction[27:26])
                            2'b00: begin
                                state_d = EXEC;
                                cnt_d   = exec_len(instruction) - CNT_W'(1);
                            end
                            2'b01:   state_d = MEM;
                            2'b10:   state_d = BRANCH;
                            default: begin
                                state_d = DONE;
                                fault_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            // cnt_q holds the remaining execute cycles after this one.
            EXEC: begin
                if (cnt_q == '0)
                    state_d = DONE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            // cnt_q counts mem_req cycles already completed before this one.
            MEM: begin
                if (mem_ack) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BRANCH:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        alu_d   = (state_d == EXEC);
        mreq_d  = (state_d == MEM);
        mwe_d   = (state_d == MEM) && we_d;
        br_d    = (state_d == BRANCH);
        ret_d   = (state_d == DONE);
        err_d   = (state_d == DONE) && fault_d;
        rcnt_d  = (state_d == DONE) ? retire_cnt + RCNT_W'(1) : retire_cnt;
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: directed and random instructions checked every cycle
// against a schedule computed from the sequencing rules.
module tb_instr_seq_ctrl;

    localparam int unsigned MUL_CYCLES  = 3;
    localparam int unsigned MEM_TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [3:0]  flags;
    logic [1:0]  instr_class;
    logic        alu_en;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        branch_en;
    logic        retired;
    logic        err;
    logic [15:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_cnt;
    logic [1:0]  exp_cls;

    instr_seq_ctrl #(.MUL_CYCLES(MUL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .flags(flags),
        .instr_class(instr_class),
        .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .branch_en(branch_en), .retired(retired), .err(err),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model's expectation.
    task automatic check_cycle(input logic ready, input logic alu, input logic mreq,
                               input logic we, input logic br, input logic ret,
                               input logic er);
        chkb("instr_ready", instr_ready, ready);
        chkb("alu_en", alu_en, alu);
        chkb("mem_req", mem_req, mreq);
        if (mreq) chkb("mem_we", mem_we, we);
        chkb("branch_en", branch_en, br);
        chkb("retired", retired, ret);
        chkb("err", err, er);
        chkw("instr_class", int'(instr_class), int'(exp_cls));
        chkw("retire_cnt", int'(retire_cnt), int'(exp_cnt));
    endtask

    // Execute cycles of a data-processing instruction.
    function automatic int dp_len(input logic [31:0] i);
        if (i[27:24] == 4'h0 && i[7:4] == 4'h9) return int'(MUL_CYCLES);
        if (!i[25] && !i[7] && i[4]) return 2;
        return 1;
    endfunction

    function automatic bit cond_ok(input logic [31:0] i, input logic [3:0] f);
`ifdef INSTR_SEQ_COND_CHECK_EN
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (i[31:28])
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
`else
        return (i[0] | ~i[0]) && (f[0] | ~f[0]);
`endif
    endfunction

    // Issue one instruction while idle and check it through to the following idle cycle.
    // ack_d: cycle after accept on which mem_ack is raised (beyond MEM_TIMEOUT = never).
    // lit_lat / lit_alu: hand-computed expectations, negative to skip.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input int ack_d,
                             input int lit_lat, input int lit_alu);
        int  kind;   // 0 none, 1 DP, 2 LS, 3 BR
        int  work;
        bit  er;
        int  lat_obs;
        int  alu_obs;
        instr_valid = 1'b1;
        instruction = ins;
        flags       = fl;
        mem_ack     = 1'($urandom);
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = $urandom;
        flags       = 4'($urandom);
        exp_cls     = ins[27:26];
        kind = 0; work = 0; er = 1'b0;
        if (cond_ok(ins, fl)) begin
            case (ins[27:26])
                2'b00: begin kind = 1; work = dp_len(ins); end
                2'b01: begin
                    kind = 2;
                    if (ack_d <= int'(MEM_TIMEOUT)) work = ack_d;
                    else begin work = int'(MEM_TIMEOUT); er = 1'b1; end
                end
                2'b10: begin kind = 3; work = 1; end
                default: er = 1'b1;
            endcase
        end
        lat_obs = 0;
        alu_obs = 0;
        for (int k = 1; k <= work; k++) begin
            check_cycle(1'b0, kind == 1, kind == 2, ~ins[20], kind == 3, 1'b0, 1'b0);
            if (alu_en) alu_obs++;
            if (retired && lat_obs == 0) lat_obs = k;
            if (kind == 2) mem_ack = (k == ack_d);
            else mem_ack = 1'($urandom);
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'd1;
        check_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, er);
        if (retired && lat_obs == 0) lat_obs = work + 1;
        mem_ack = 1'($urandom);
        @(negedge clk);
        check_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (lit_lat >= 0) chkw("latency", lat_obs, lit_lat);
        if (lit_alu >= 0) chkw("alu_cycles", alu_obs, lit_alu);
    endtask

    task automatic check_reset_outputs();
        chkb("rst instr_ready", instr_ready, 1'b0);
        chkb("rst alu_en", alu_en, 1'b0);
        chkb("rst mem_req", mem_req, 1'b0);
        chkb("rst mem_we", mem_we, 1'b0);
        chkb("rst branch_en", branch_en, 1'b0);
        chkb("rst retired", retired, 1'b0);
        chkb("rst err", err, 1'b0);
        chkw("rst instr_class", int'(instr_class), 0);
        chkw("rst retire_cnt", int'(retire_cnt), 0);
    endtask

    initial begin
        logic [31:0] ins;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        flags       = '0;
        mem_ack     = 1'b0;
        exp_cnt     = '0;
        exp_cls     = '0;
        #2;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed cases with hand-computed latencies.
        run_instr(32'hE0810002, 4'h0, 0, 2, 1);              // ADD
        chkw("cnt after ADD", int'(retire_cnt), 1);
        run_instr(32'hE0000291, 4'h0, 0, 4, 3);              // MUL
        run_instr(32'hE0810312, 4'h0, 0, 3, 2);              // register-shifted
        run_instr(32'hE5910000, 4'h0, 4, 5, -1);             // LDR, ack at t+4
        run_instr(32'hE5810000, 4'h0, 2, 3, -1);             // STR, ack at t+2
        run_instr(32'hE5910000, 4'h0, 1000, 16, -1);         // LDR timeout
        run_instr(32'hE0810002, 4'h0, 0, 2, 1);              // accept right after timeout
        run_instr(32'hEA000000, 4'h0, 0, 2, -1);             // B
        run_instr(32'hEC000000, 4'h0, 0, 1, -1);             // UND
        chkw("cnt after directed", int'(retire_cnt), 9);
`ifdef INSTR_SEQ_COND_CHECK_EN
        run_instr(32'h00810002, 4'h0, 0, 1, 0);              // ADDEQ with Z=0
`endif

        // Random instructions with random idle gaps and stray mem_ack.
        for (int n = 0; n < 250; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ins[27:24] = 4'h0;
                ins[7:4]   = 4'h9;
            end
            run_instr(ins, 4'($urandom), int'($urandom_range(1, 18)), -1, -1);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                mem_ack = 1'($urandom);
                @(negedge clk);
                check_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        // Reset in the middle of a multiply aborts it and clears the count.
        instr_valid = 1'b1;
        instruction = 32'hE0000291;
        flags       = 4'h0;
        mem_ack     = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        chkb("mul alu_en before reset", alu_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_cnt = '0;
        exp_cls = '0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(32'hE0810002, 4'h0, 0, 2, 1);
        chkw("cnt after reset+ADD", int'(retire_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
